// File: rtl/riscv_pkg.sv
// Shared decode-bundle types plus the issue-controller state enum and load classifier.
package riscv_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [3:0] {
    LSU_NONE,
    LSU_LB,
    LSU_LH,
    LSU_LW,
    LSU_LBU,
    LSU_LHU,
    LSU_SB,
    LSU_SH,
    LSU_SW
  } lsu_op_t;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             reg_write;
    lsu_op_t          lsu_op;
    logic             illegal;
  } dec_out_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    TRAP,
    HALT
  } issue_state_t;

  // Loads occupy LSU_LB..LSU_LHU in the encoding; everything above is a store.
  function automatic logic is_load(lsu_op_t op);
    return (op >= LSU_LB) && (op <= LSU_LHU);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register pending-load bits and the outstanding-load counter.
module issue_scoreboard
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_LD = 2,
  parameter int unsigned NREG   = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            set_i,
  input  logic [REG_W-1:0]                set_idx_i,
  input  logic                            clr_i,
  input  logic [REG_W-1:0]                clr_idx_i,
  input  logic                            cnt_inc_i,
  input  logic                            cnt_dec_i,
  output logic [NREG-1:0]                 busy_o,
  output logic [$clog2(MAX_LD+1)-1:0]     ld_cnt_o
);

  localparam int unsigned CNT_W = $clog2(MAX_LD + 1);

  logic [NREG-1:0]  r_busy;
  logic [NREG-1:0]  w_busy_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rsp_ok;
  logic             w_dec;

  // A response with nothing outstanding is a protocol error and is dropped entirely.
  assign w_rsp_ok = (r_cnt != '0);
  assign w_dec    = cnt_dec_i && w_rsp_ok;

  always_comb begin
    w_busy_nxt = r_busy;
    if (clr_i && w_rsp_ok && (32'(clr_idx_i) < NREG)) begin
      w_busy_nxt[clr_idx_i] = 1'b0;
    end
    if (set_i && (32'(set_idx_i) < NREG)) begin
      w_busy_nxt[set_idx_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (cnt_inc_i && !w_dec) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (!cnt_inc_i && w_dec) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign busy_o   = r_busy;
  assign ld_cnt_o = r_cnt;

endmodule

// File: rtl/issue_ctrl.sv
// Decode-to-EX issue gate: load scoreboard hazards, redirect flushes, illegal-op trap FSM.
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module issue_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_LD = 2,
  parameter int unsigned NREG   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         id_valid_i,
  input  dec_out_t                     id_dec_i,
  output logic                         id_ready_o,
  output logic                         issue_o,
  output logic                         stall_if_o,
  output logic                         flush_if_o,
  output logic                         flush_id_o,
  input  logic                         ex_redirect_i,
  input  logic                         lsu_req_ready_i,
  input  logic                         lsu_rsp_valid_i,
  input  logic [4:0]                   lsu_rsp_rd_i,
  input  logic                         restart_i,
  output logic                         trap_o,
  output logic                         halted_o,
  output logic [$clog2(MAX_LD+1)-1:0]  ld_cnt_o,
  output logic [NREG-1:0]              busy_o,
  output logic [31:0]                  perf_issue_o,
  output logic [31:0]                  perf_stall_o
);

  localparam int unsigned CNT_W = $clog2(MAX_LD + 1);

  issue_state_t     r_state;
  logic             r_trap;
  logic             r_halted;

  logic [NREG-1:0]  w_busy;
  logic [CNT_W-1:0] w_ld_cnt;
  logic             w_is_load;
  logic             w_haz_rs1;
  logic             w_haz_rs2;
  logic             w_haz_waw;
  logic             w_haz_mem;
  logic             w_haz_cnt;
  logic             w_hazard;
  logic             w_run;
  logic             w_id_ready;
  logic             w_issue;
  logic             w_flush;
  logic             w_ld_issue;

  issue_scoreboard #(
    .MAX_LD (MAX_LD),
    .NREG   (NREG)
  ) u_sb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (w_ld_issue && (id_dec_i.rd != '0)),
    .set_idx_i (id_dec_i.rd),
    .clr_i     (lsu_rsp_valid_i),
    .clr_idx_i (lsu_rsp_rd_i),
    .cnt_inc_i (w_ld_issue),
    .cnt_dec_i (lsu_rsp_valid_i),
    .busy_o    (w_busy),
    .ld_cnt_o  (w_ld_cnt)
  );

  // Hazards look only at registered scoreboard state; a same-cycle response does not bypass.
  assign w_is_load = is_load(id_dec_i.lsu_op);
  assign w_haz_rs1 = id_dec_i.uses_rs1 && (id_dec_i.rs1 != '0) && w_busy[id_dec_i.rs1];
  assign w_haz_rs2 = id_dec_i.uses_rs2 && (id_dec_i.rs2 != '0) && w_busy[id_dec_i.rs2];
  assign w_haz_waw = id_dec_i.reg_write && (id_dec_i.rd != '0) && w_busy[id_dec_i.rd];
  assign w_haz_mem = (id_dec_i.lsu_op != LSU_NONE) && !lsu_req_ready_i;
  assign w_haz_cnt = w_is_load && (w_ld_cnt == CNT_W'(MAX_LD));
  assign w_hazard  = w_haz_rs1 || w_haz_rs2 || w_haz_waw || w_haz_mem || w_haz_cnt;

  // Held in reset, nothing is consumed or flushed even though the state already reads RUN.
  assign w_run      = (r_state == RUN) && !rst_i;
  assign w_flush    = w_run && ex_redirect_i;
  assign w_id_ready = w_run && !ex_redirect_i && id_valid_i && (id_dec_i.illegal || !w_hazard);
  assign w_issue    = w_id_ready && !id_dec_i.illegal;
  assign w_ld_issue = w_issue && w_is_load;

  assign id_ready_o = w_id_ready;
  assign issue_o    = w_issue;
  assign flush_if_o = w_flush;
  assign flush_id_o = w_flush;
  assign stall_if_o = (r_state != RUN) || (id_valid_i && !w_id_ready && !w_flush);

  // Trap sequencing: wait for outstanding loads, pulse trap once, then park until restart.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= RUN;
      r_trap   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_id_ready && id_dec_i.illegal) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_ld_cnt == '0) begin
            r_state <= TRAP;
            r_trap  <= 1'b1;
          end
        end
        TRAP: begin
          r_state  <= HALT;
          r_trap   <= 1'b0;
          r_halted <= 1'b1;
        end
        HALT: begin
          if (restart_i) begin
            r_state  <= RUN;
            r_halted <= 1'b0;
          end
        end
      endcase
    end
  end

  assign trap_o   = r_trap;
  assign halted_o = r_halted;
  assign ld_cnt_o = w_ld_cnt;
  assign busy_o   = w_busy;

`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_issue) begin
        r_perf_issue <= r_perf_issue + 32'd1;
      end
      if (w_run && id_valid_i && !ex_redirect_i && !w_id_ready) begin
        r_perf_stall <= r_perf_stall + 32'd1;
      end
    end
  end

  assign perf_issue_o = r_perf_issue;
  assign perf_stall_o = r_perf_stall;
`else
  assign perf_issue_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule
